// File: rtl/display_pkg.sv
// Shared types and helpers for the time-shared hex display controller.
// The display word width and the one-hot decoding used by the round-robin picker live here.
package display_pkg;

  typedef enum logic {IDLE, SHOW} disp_state_t;

  localparam int DISP_W  = 16;
  localparam int MAX_REQ = 8;

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) begin
        idx = idx | 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward
// from last+1, wrapping, so the previous winner is considered last.
module rr_pick
  import display_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [MAX_REQ-1:0] onehot_wide;
  logic [2:0]         idx_wide;
  logic               found;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        onehot[(int'(last) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    onehot_wide = '0;
    onehot_wide[N-1:0] = onehot;
  end

  assign idx_wide = onehot_to_idx(onehot_wide);
  assign idx      = idx_wide[IW-1:0];
  assign any      = |req;

endmodule

// File: rtl/display_share_ctrl.sv
// Time-shares one 16-bit hex display among NREQ requesters, round-robin,
// with a guaranteed minimum dwell per grant before another owner can take over.
module display_share_ctrl
  import display_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DWELL = 50_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [DISP_W*NREQ-1:0] vals,
  output logic [NREQ-1:0]        grant,
  output logic [DISP_W-1:0]      disp_val,
  output logic                   disp_blank,
  output logic                   dwell_done
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

  disp_state_t         state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [DISP_W-1:0]   disp_val_q, disp_val_d;
  logic                disp_blank_q, disp_blank_d;
  logic                dwell_done_q, dwell_done_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       last_q, last_d;

  logic                pick_any;
  logic [IW-1:0]       pick_idx;
  logic [NREQ-1:0]     pick_onehot;
  logic                owner_req;
  logic [DISP_W-1:0]   val_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_vals
      assign val_arr[gi] = vals[DISP_W*gi +: DISP_W];
    end
  endgenerate

  rr_pick #(.N(NREQ)) u_pick (
    .req    (req),
    .last   (last_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // In SHOW, last_q always names the current owner.
  assign owner_req = req[last_q];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    disp_val_d   = disp_val_q;
    disp_blank_d = disp_blank_q;
    dwell_done_d = dwell_done_q;
    cnt_d        = cnt_q;
    last_d       = last_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d      = SHOW;
          grant_d      = pick_onehot;
          last_d       = pick_idx;
          cnt_d        = CNT_LOAD;
          dwell_done_d = 1'b0;
          disp_blank_d = 1'b0;
          disp_val_d   = val_arr[pick_idx];
        end
      end

      SHOW: begin
        disp_val_d = val_arr[last_q];
        // Re-arbitrate once the dwell is over or the owner has let go early.
        if (!owner_req || dwell_done_q) begin
          if (!pick_any) begin
            state_d      = IDLE;
            grant_d      = '0;
            disp_blank_d = 1'b1;
            disp_val_d   = disp_val_q;
            dwell_done_d = 1'b0;
            cnt_d        = '0;
          end else if (pick_idx != last_q) begin
            grant_d      = pick_onehot;
            last_d       = pick_idx;
            cnt_d        = CNT_LOAD;
            dwell_done_d = 1'b0;
            disp_val_d   = val_arr[pick_idx];
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            dwell_done_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      disp_val_q   <= '0;
      disp_blank_q <= 1'b1;
      dwell_done_q <= 1'b0;
      cnt_q        <= '0;
      last_q       <= IW'(NREQ - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      disp_val_q   <= disp_val_d;
      disp_blank_q <= disp_blank_d;
      dwell_done_q <= dwell_done_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
    end
  end

  assign grant      = grant_q;
  assign disp_val   = disp_val_q;
  assign disp_blank = disp_blank_q;
  assign dwell_done = dwell_done_q;

endmodule

// File: tb/tb_display_share_ctrl.sv
// Self-checking bench for display_share_ctrl: directed scenarios followed by
// randomized requests, all compared against an edge-level ownership model.
module tb_display_share_ctrl;

  localparam int NREQ  = 4;
  localparam int DWELL = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [16*NREQ-1:0]    vals;
  logic [NREQ-1:0]       grant;
  logic [15:0]           disp_val;
  logic                  disp_blank;
  logic                  dwell_done;

  int errors = 0;
  int checks = 0;

  // Model: owner index (-1 idle), edges since the grant edge, rotate pointer, shown value.
  int          m_owner;
  int          m_age;
  int          m_last;
  logic [15:0] m_val;

  always #5 clk = ~clk;

  display_share_ctrl #(.NREQ(NREQ), .DWELL(DWELL)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .vals       (vals),
    .grant      (grant),
    .disp_val   (disp_val),
    .disp_blank (disp_blank),
    .dwell_done (dwell_done)
  );

  function automatic logic [15:0] val_of(input int i);
    return vals[16*i +: 16];
  endfunction

  function automatic int pick();
    for (int k = 1; k <= NREQ; k++) begin
      if (req[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_last  = NREQ - 1;
    m_val   = 16'h0000;
  endtask

  task automatic model_grant(input int w);
    m_owner = w;
    m_age   = 0;
    m_last  = w;
    m_val   = val_of(w);
  endtask

  task automatic model_edge();
    int w;
    if (m_owner < 0) begin
      w = pick();
      if (w >= 0) model_grant(w);
    end else if (!req[m_owner] || m_age >= DWELL - 1) begin
      w = pick();
      if (w < 0) m_owner = -1;
      else if (w != m_owner) model_grant(w);
      else m_val = val_of(m_owner);
    end else begin
      m_age++;
      m_val = val_of(m_owner);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NREQ-1:0] exp_grant;
    exp_grant = (m_owner < 0) ? '0 : NREQ'(1 << m_owner);
    check({tag, ".grant"},      32'(grant),      32'(exp_grant));
    check({tag, ".disp_val"},   32'(disp_val),   32'(m_val));
    check({tag, ".disp_blank"}, 32'(disp_blank), 32'(m_owner < 0));
    check({tag, ".dwell_done"}, 32'(dwell_done), 32'(m_owner >= 0 && m_age >= DWELL - 1));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    vals  = '0;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk);
    #3 reset = 1'b0;

    // First grant from IDLE and dwell timing.
    vals[0 +: 16] = 16'h1234;
    req = 4'b0001;
    tick("first_grant");
    check("first_grant.explicit_grant", 32'(grant), 32'h1);
    check("first_grant.explicit_val", 32'(disp_val), 32'h1234);
    $display("step first_grant: grant=%b disp_val=%h", grant, disp_val);

    // Second requester arrives during dwell; handover only after dwell.
    tick("hold_e1");
    req = 4'b0101;
    for (int i = 2; i <= 8; i++) tick("hold_wait");
    check("handover.explicit_grant", 32'(grant), 32'h4);
    check("handover.explicit_blank", 32'(disp_blank), 32'h0);
    $display("step handover: grant=%b blank=%b", grant, disp_blank);

    // Everyone requesting: strict rotation, DWELL cycles each.
    req = 4'b1111;
    for (int i = 0; i < 40; i++) tick("rotate");
    $display("step rotate: grant=%b", grant);

    // Owner 1 drops early with no other requesters.
    req = '0;
    tick("drain");
    tick("drain");
    vals[16 +: 16] = 16'hBEEF;
    req = 4'b0010;
    tick("owner1_grant");
    check("owner1.explicit_grant", 32'(grant), 32'h2);
    for (int i = 0; i < 3; i++) tick("owner1_dwell");
    req = '0;
    tick("early_release");
    check("early_release.explicit_grant", 32'(grant), 32'h0);
    check("early_release.explicit_blank", 32'(disp_blank), 32'h1);
    check("early_release.explicit_val", 32'(disp_val), 32'hBEEF);
    $display("step early_release: grant=%b blank=%b disp_val=%h", grant, disp_blank, disp_val);

    // Live value tracking for owner 2.
    vals[32 +: 16] = 16'hAAAA;
    req = 4'b0100;
    tick("owner2_grant");
    tick("owner2_dwell");
    vals[32 +: 16] = 16'h5555;
    tick("owner2_track");
    check("track.explicit_val", 32'(disp_val), 32'h5555);
    check("track.explicit_grant", 32'(grant), 32'h4);
    $display("step track: grant=%b disp_val=%h", grant, disp_val);

    // Asynchronous reset between edges.
    tick("owner2_more");
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    check("async_reset.explicit_blank", 32'(disp_blank), 32'h1);
    @(posedge clk);
    #3;
    check_all("reset_held");
    reset = 1'b0;
    vals[48 +: 16] = 16'hCAFE;
    req = 4'b1000;
    tick("after_reset");
    check("after_reset.explicit_grant", 32'(grant), 32'h8);
    check("after_reset.explicit_val", 32'(disp_val), 32'hCAFE);
    $display("step after_reset: grant=%b disp_val=%h", grant, disp_val);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) req = NREQ'($urandom);
      vals[16*$urandom_range(NREQ-1) +: 16] = 16'($urandom);
      tick("rand");
    end
    $display("step random: done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
